// File: rtl/full_i2c_controller.sv
// Receive-only I2C slave: synchronizes and deglitches SCL/SDA on FCLK, then
// captures bytes written to SLAVE_ADDR and presents each one with a one-cycle strobe.
module full_i2c_controller #(
  parameter logic [6:0] SLAVE_ADDR    = 7'h5A,
  parameter int         GLITCH_CYCLES = 3
) (
  input  logic       FCLK,
  input  logic       RST,
  input  logic       CLK,
  input  logic       DATA,
  output logic [7:0] CIRCUIT_OUT_DATA,
  output logic       DATA_VALID,
  output logic [2:0] fsm_state       // debug view of the FSM, IDLE reads as 0
);

  localparam int CW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_DATA     = 3'd3,
    S_DATA_ACK = 3'd4,
    S_IGNORE   = 3'd5
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA through the whole front end.
  logic [1:0]    sync1, sync2, filt, filt_d;
  logic [CW-1:0] flt_cnt [2];

  always_ff @(posedge FCLK or posedge RST) begin
    if (RST) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      filt       <= 2'b11;
      filt_d     <= 2'b11;
      flt_cnt[0] <= '0;
      flt_cnt[1] <= '0;
    end else begin
      sync1  <= {DATA, CLK};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CW'(GLITCH_CYCLES - 1)) begin
          filt[i]    <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic scl, scl_d, sda, sda_d;
  logic scl_rise, start_det, stop_det;

  assign scl   = filt[0];
  assign scl_d = filt_d[0];
  assign sda   = filt[1];
  assign sda_d = filt_d[1];

  // SCL must be high in both samples, so an SDA edge coinciding with an SCL
  // edge can never be mistaken for START or STOP.
  assign scl_rise  = scl & ~scl_d;
  assign start_det = scl & scl_d & ~sda & sda_d;
  assign stop_det  = scl & scl_d & sda & ~sda_d;

  state_t     state, state_nxt;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt;
  logic [7:0] byte_nxt;
  logic       last_bit;

  assign byte_nxt  = {shift_q[6:0], sda};
  assign last_bit  = scl_rise && (bit_cnt == 3'd7);
  assign fsm_state = state;

  always_ff @(posedge FCLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = S_IDLE;
    end else if (start_det) begin
      state_nxt = S_ADDR;
    end else begin
      case (state)
        S_ADDR: begin
          if (last_bit)
            state_nxt = (byte_nxt[7:1] == SLAVE_ADDR && !byte_nxt[0]) ? S_ADDR_ACK : S_IGNORE;
        end
        S_ADDR_ACK: if (scl_rise) state_nxt = S_DATA;
        S_DATA:     if (last_bit) state_nxt = S_DATA_ACK;
        S_DATA_ACK: if (scl_rise) state_nxt = S_DATA;
        default:    state_nxt = state;
      endcase
    end
  end

  logic shift_clr, shift_en, cnt_clr, load_byte;

  always_comb begin
    shift_clr = start_det;
    cnt_clr   = start_det || (state == S_ADDR_ACK && scl_rise);
    shift_en  = scl_rise && (state == S_ADDR || state == S_DATA);
    load_byte = (state == S_DATA) && last_bit;
  end

  always_ff @(posedge FCLK or posedge RST) begin
    if (RST) begin
      shift_q          <= 8'h00;
      bit_cnt          <= 3'd0;
      CIRCUIT_OUT_DATA <= 8'h00;
      DATA_VALID       <= 1'b0;
    end else begin
      DATA_VALID <= load_byte;
      if (load_byte) CIRCUIT_OUT_DATA <= byte_nxt;
      if (shift_clr)     shift_q <= 8'h00;
      else if (shift_en) shift_q <= byte_nxt;
      if (cnt_clr)       bit_cnt <= 3'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_full_i2c_controller.sv
// Bench for full_i2c_controller: bit-banged I2C write transfers with glitches,
// checked against a transfer-level model of which bytes must be delivered.
module tb_full_i2c_controller;

  localparam logic [6:0] SLV  = 7'h5A;
  localparam int         G    = 3;
  localparam int         Q    = 4;
  localparam int         LAT  = 2 + G + 1;

  logic       fclk   = 1'b0;
  logic       rst    = 1'b1;
  logic       clk_i  = 1'b1;
  logic       data_i = 1'b1;
  logic [7:0] out_data;
  logic       valid;
  logic [2:0] fsm_state;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         last_rise = 0;
  int         n_exp    = 0;
  int         n_seen   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_out = 8'h00;
  logic       xfer_match = 1'b0;
  logic [7:0] mon_exp;

  full_i2c_controller #(.SLAVE_ADDR(SLV), .GLITCH_CYCLES(G)) dut (
    .FCLK             (fclk),
    .RST              (rst),
    .CLK              (clk_i),
    .DATA             (data_i),
    .CIRCUIT_OUT_DATA (out_data),
    .DATA_VALID       (valid),
    .fsm_state        (fsm_state)
  );

  // clock / cycle counter
  always #5 fclk = ~fclk;
  always @(posedge fclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every strobe must match the oldest outstanding byte
  always @(negedge fclk) begin
    if (!rst && valid) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        check_eq("valid_without_expected_byte", {31'd0, valid}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("rx_byte", {24'd0, out_data}, {24'd0, mon_exp});
        check_eq("valid_latency", cyc - last_rise, LAT);
      end
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge fclk);
  endtask

  task automatic drive_bit(input logic b, input int gw);
    clk_i = 1'b0;
    wait_cyc(Q);
    data_i = b;
    wait_cyc(Q);
    clk_i = 1'b1;
    last_rise = cyc;
    if (gw > 0) begin
      wait_cyc(2);
      data_i = ~b;
      wait_cyc(gw);
      data_i = b;
      wait_cyc(2 * Q - 2 - gw);
    end else begin
      wait_cyc(2 * Q);
    end
    clk_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gbit, input int gw);
    for (int i = 7; i >= 0; i--) drive_bit(d[i], (i == gbit) ? gw : 0);
    drive_bit(1'b1, 0);
  endtask

  task automatic start_cond();
    if (!clk_i) begin
      wait_cyc(Q);
      data_i = 1'b1;
      wait_cyc(Q);
      clk_i = 1'b1;
    end
    wait_cyc(Q);
    data_i = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic stop_cond();
    clk_i = 1'b0;
    wait_cyc(Q);
    data_i = 1'b0;
    wait_cyc(Q);
    clk_i = 1'b1;
    wait_cyc(Q);
    data_i = 1'b1;
    wait_cyc(2 * Q);
    xfer_match = 1'b0;
  endtask

  task automatic send_addr(input logic [7:0] a, input int gbit, input int gw);
    start_cond();
    xfer_match = (a[7:1] == SLV) && !a[0];
    send_byte(a, gbit, gw);
  endtask

  task automatic send_data(input logic [7:0] d, input int gbit, input int gw);
    if (xfer_match) begin
      exp_q.push_back(d);
      model_out = d;
      n_exp++;
    end
    send_byte(d, gbit, gw);
    check_eq("out_hold", {24'd0, out_data}, {24'd0, model_out});
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] part;
    int nb;

    // reset state
    wait_cyc(3);
    check_eq("reset_out", {24'd0, out_data}, 32'h00);
    check_eq("reset_valid", {31'd0, valid}, 32'd0);
    check_eq("reset_state", {29'd0, fsm_state}, 32'd0);
    rst = 1'b0;
    wait_cyc(4);

    // addressed write, multi-byte, then STOP
    send_addr(8'hB4, -1, 0);
    send_data(8'hA5, -1, 0);
    send_data(8'h3C, -1, 0);
    send_data(8'hFF, -1, 0);
    stop_cond();
    check_eq("idle_after_stop", {29'd0, fsm_state}, 32'd0);

    // mismatched address and read request
    send_addr(8'h24, -1, 0);
    send_data(8'h77, -1, 0);
    stop_cond();
    send_addr(8'hB5, -1, 0);
    send_data(8'h77, -1, 0);
    stop_cond();

    // 1-cycle SDA glitches while SCL high, on a 1 bit and on a 0 bit
    send_addr(8'hB4, -1, 0);
    send_data(8'h96, 7, 1);
    send_data(8'h96, 5, 1);
    stop_cond();

    // repeated START after a partial byte
    send_addr(8'hB4, -1, 0);
    part = 8'hC3;
    for (int i = 7; i >= 4; i--) drive_bit(part[i], 0);
    send_addr(8'hB4, -1, 0);
    send_data(8'h0F, -1, 0);
    stop_cond();

    // reset mid-byte after a received byte
    send_addr(8'hB4, -1, 0);
    send_data(8'hA5, -1, 0);
    part = 8'h5A;
    for (int i = 7; i >= 4; i--) drive_bit(part[i], 0);
    @(negedge fclk);
    rst = 1'b1;
    #1;
    model_out = 8'h00;
    xfer_match = 1'b0;
    check_eq("midbyte_reset_out", {24'd0, out_data}, 32'h00);
    check_eq("midbyte_reset_valid", {31'd0, valid}, 32'd0);
    check_eq("midbyte_reset_state", {29'd0, fsm_state}, 32'd0);
    @(negedge fclk);
    rst = 1'b0;
    for (int i = 3; i >= 0; i--) drive_bit(part[i], 0);
    drive_bit(1'b1, 0);
    send_data(8'hB4, -1, 0);
    send_data(8'h3D, -1, 0);
    stop_cond();
    check_eq("post_reset_out", {24'd0, out_data}, 32'h00);

    // randomized transfers with sub-threshold glitches
    for (int t = 0; t < 14; t++) begin
      a = ($urandom_range(0, 1) == 1) ? {SLV, 1'b0} : 8'($urandom_range(0, 255));
      send_addr(a, $urandom_range(0, 7), $urandom_range(0, G - 1));
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++)
        send_data(8'($urandom_range(0, 255)), $urandom_range(0, 7), $urandom_range(0, G - 1));
      stop_cond();
      check_eq("rand_idle", {29'd0, fsm_state}, 32'd0);
    end

    // final report
    wait_cyc(4 * Q);
    check_eq("pending_bytes", exp_q.size(), 32'd0);
    check_eq("strobe_count", n_seen, n_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/full_i2c_controller.md
FULL_I2C_CONTROLLER -- requirements
Module: full_i2c_controller

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h5A: 7-bit slave address this block answers to.
REQ-002 Parameter GLITCH_CYCLES, default 3: consecutive FCLK samples an input must hold a new level before the filtered copy accepts it.
REQ-003 FCLK  input  1  sole clock of the block, all state changes on its rising edge; at least 8x the SCL bit rate.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 CLK  input  1  I2C SCL line, asynchronous to FCLK; treated as data, sampled by FCLK, never used as a clock.
REQ-006 DATA  input  1  I2C SDA line, asynchronous to FCLK; receive-only (no ACK drive).
REQ-007 CIRCUIT_OUT_DATA  output  8  last data byte received by an addressed write transfer.
REQ-008 DATA_VALID  output  1  one-FCLK pulse when CIRCUIT_OUT_DATA is updated.

Function
REQ-009 CLK and DATA SHALL each pass a 2-flop FCLK synchronizer, then a glitch filter whose output changes only after the synchronized input holds the new level for GLITCH_CYCLES consecutive FCLK samples.
REQ-010 Filtered SCL/SDA SHALL be registered once more for edge detection; all detection uses the filtered signals only.
REQ-011 START SHALL be detected when filtered SDA falls while filtered SCL is high in both current and previous sample; STOP when filtered SDA rises under the same SCL condition.
REQ-012 An SDA edge in the same FCLK cycle as an SCL edge SHALL not be treated as START or STOP.
REQ-013 Data bits SHALL be sampled on filtered SCL rising edges, MSB first, into an 8-bit shift register with a 0..7 bit counter.
REQ-014 FSM states SHALL be IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-015 IDLE: on START -> ADDR with bit counter and shift register cleared; all SCL edges otherwise ignored.
REQ-016 ADDR: after 8th bit, if bits[7:1]==SLAVE_ADDR and bit[0]==0 (write) -> ADDR_ACK, else -> IGNORE.
REQ-017 ADDR_ACK: the next SCL rising edge (9th clock) SHALL be consumed without sampling -> DATA with counter cleared.
REQ-018 DATA: on 8th bit, CIRCUIT_OUT_DATA SHALL load {shift[6:0], sampled bit} and DATA_VALID SHALL pulse high for exactly one FCLK cycle, in the same cycle; -> DATA_ACK.
REQ-019 DATA_ACK: next SCL rising edge consumed -> DATA; unlimited bytes per transfer.
REQ-020 IGNORE: all SCL edges ignored until START or STOP.
REQ-021 STOP in any state SHALL -> IDLE; START (repeated start) in any state SHALL -> ADDR, discarding a partial byte with CIRCUIT_OUT_DATA unchanged.
REQ-022 CIRCUIT_OUT_DATA SHALL hold its value between updates; no update on mismatch, read request or partial byte.
REQ-023 Latency from a raw CLK rising edge carrying the 8th data bit to CIRCUIT_OUT_DATA update SHALL be exactly 2 + GLITCH_CYCLES + 1 FCLK cycles, given SCL and SDA are stable across that window.
REQ-024 Pulses on CLK or DATA shorter than GLITCH_CYCLES FCLK cycles SHALL have no effect on state or outputs.

Reset
REQ-025 RST high SHALL immediately force: FSM IDLE, CIRCUIT_OUT_DATA 8'h00, DATA_VALID 0, shift register and bit counter 0, synchronizer, filter and edge registers to 1 (idle bus), filter counters 0.
REQ-026 After RST release, a START SHALL be required before any bit is accepted; reset mid-byte discards that byte.

Verification
REQ-027 RST, START, address byte 8'hB4 (0x5A write), data 8'hA5 -> CIRCUIT_OUT_DATA=8'hA5 with one DATA_VALID pulse at REQ-023 latency.
REQ-028 Same transfer continuing with bytes 8'h3C, 8'hFF then STOP -> two further DATA_VALID pulses, final CIRCUIT_OUT_DATA=8'hFF, FSM IDLE.
REQ-029 Address 8'h24 (mismatch) or 8'hB5 (read) followed by data 8'h77 -> CIRCUIT_OUT_DATA unchanged, no DATA_VALID.
REQ-030 1-FCLK-wide low glitch on DATA while CLK high mid-byte -> no START/STOP, byte received correctly.
REQ-031 Repeated START after 4 data bits, then 8'hB4 and 8'h0F -> partial byte dropped, CIRCUIT_OUT_DATA=8'h0F.
REQ-032 RST asserted mid-byte after prior 8'hA5 -> CIRCUIT_OUT_DATA=8'h00 immediately, FSM IDLE, following bits ignored until START.
